// File: rtl/ctl_round.sv
// Duck Hunt round sequencer: walks a game through intermission, launch, flight,
// fly-away and round scoring, and drives the duck/ammo/score/overlay blocks.
module ctl_round #(
  parameter int DUCKS_PER_ROUND     = 10,
  parameter int MIN_HITS            = 6,
  parameter int ROUNDS_MAX          = 9,
  parameter int SHOTS_PER_DUCK      = 3,
  parameter int DUCK_TIMEOUT_FRAMES = 300,
  parameter int INTER_FRAMES        = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_frame,
  input  logic       start,
  input  logic       pause_req,
  input  logic       hit,
  input  logic       shot_fired,
  input  logic       duck_gone,
  output logic       duck_launch,
  output logic       duck_abort,
  output logic       reload,
  output logic       reset_score,
  output logic       pause,
  output logic       looser,
  output logic [3:0] round,
  output logic [3:0] duck_idx,
  output logic [3:0] round_hits,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INTER     = 3'd1,
    S_LAUNCH    = 3'd2,
    S_FLYING    = 3'd3,
    S_FLY_AWAY  = 3'd4,
    S_DUCK_DONE = 3'd5,
    S_ROUND_END = 3'd6,
    S_GAME_OVER = 3'd7
  } state_t;

  localparam logic [9:0] INTER_LD   = 10'(INTER_FRAMES);
  localparam logic [9:0] TIMEOUT_LD = 10'(DUCK_TIMEOUT_FRAMES);
  localparam logic [2:0] SHOT_LIM   = 3'(SHOTS_PER_DUCK);
  localparam logic [3:0] DUCK_LIM   = 4'(DUCKS_PER_ROUND);
  localparam logic [3:0] HIT_MIN    = 4'(MIN_HITS);
  localparam logic [3:0] ROUND_LIM  = 4'(ROUNDS_MAX);

  state_t     st_q;
  logic [9:0] frames;
  logic [2:0] shots;

  // Play events are masked while paused; duck_gone is deliberately never masked.
  logic frame_tick;
  logic shot_tick;
  logic hit_tick;
  logic frames_last;
  logic shots_last;

  always_comb begin
    frame_tick  = new_frame  & ~pause_req;
    shot_tick   = shot_fired & ~pause_req & ~hit;
    hit_tick    = hit        & ~pause_req;
    frames_last = (frames <= 10'd1);
    shots_last  = ((shots + 3'd1) >= SHOT_LIM);
  end

  assign state = st_q;

  // duck_launch, reload and reset_score are single-cycle strobes with no
  // acknowledge: downstream blocks must act on the cycle they are seen high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q        <= S_IDLE;
      frames      <= 10'd0;
      shots       <= 3'd0;
      round       <= 4'd0;
      duck_idx    <= 4'd0;
      round_hits  <= 4'd0;
      duck_launch <= 1'b0;
      duck_abort  <= 1'b0;
      reload      <= 1'b0;
      reset_score <= 1'b0;
      pause       <= 1'b1;
      looser      <= 1'b0;
    end else begin
      duck_launch <= 1'b0;
      reload      <= 1'b0;
      reset_score <= 1'b0;

      case (st_q)
        S_IDLE, S_GAME_OVER: begin
          pause <= 1'b1;
          if (start) begin
            st_q        <= S_INTER;
            frames      <= INTER_LD;
            round       <= 4'd1;
            duck_idx    <= 4'd0;
            round_hits  <= 4'd0;
            reset_score <= 1'b1;
            reload      <= 1'b1;
            looser      <= 1'b0;
            pause       <= pause_req;
          end
        end

        S_INTER: begin
          pause <= pause_req;
          if (frame_tick) begin
            if (frames_last) begin
              st_q        <= S_LAUNCH;
              frames      <= 10'd0;
              duck_launch <= 1'b1;
              pause       <= 1'b0;
            end else begin
              frames <= frames - 10'd1;
            end
          end
        end

        S_LAUNCH: begin
          st_q   <= S_FLYING;
          shots  <= 3'd0;
          frames <= TIMEOUT_LD;
          pause  <= pause_req;
        end

        S_FLYING: begin
          pause <= pause_req;
          if (hit_tick) begin
            st_q       <= S_DUCK_DONE;
            round_hits <= round_hits + 4'd1;
          end else begin
            if (shot_tick) shots <= shots + 3'd1;
            if (frame_tick && !frames_last) frames <= frames - 10'd1;
            // Last shot and timer expiry together still make one fly-away.
            if ((shot_tick && shots_last) || (frame_tick && frames_last)) begin
              st_q       <= S_FLY_AWAY;
              frames     <= 10'd0;
              duck_abort <= 1'b1;
            end
          end
        end

        S_FLY_AWAY: begin
          pause <= pause_req;
          if (duck_gone) begin
            st_q       <= S_DUCK_DONE;
            duck_abort <= 1'b0;
            pause      <= 1'b0;
          end
        end

        S_DUCK_DONE: begin
          duck_idx <= duck_idx + 4'd1;
          reload   <= 1'b1;
          if ((duck_idx + 4'd1) == DUCK_LIM) begin
            st_q  <= S_ROUND_END;
            pause <= 1'b0;
          end else begin
            st_q   <= S_INTER;
            frames <= INTER_LD;
            pause  <= pause_req;
          end
        end

        S_ROUND_END: begin
          if (round_hits < HIT_MIN) begin
            st_q   <= S_GAME_OVER;
            looser <= 1'b1;
            pause  <= 1'b1;
          end else if (round == ROUND_LIM) begin
            st_q   <= S_GAME_OVER;
            pause  <= 1'b1;
          end else begin
            st_q       <= S_INTER;
            frames     <= INTER_LD;
            round      <= round + 4'd1;
            duck_idx   <= 4'd0;
            round_hits <= 4'd0;
            pause      <= pause_req;
          end
        end

        default: begin
          st_q  <= S_IDLE;
          pause <= 1'b1;
        end
      endcase
    end
  end

endmodule
